// File: rtl/vend_pkg.sv
// Shared types and constants for the vending session controller.
// Holds the state encoding, the coin decode and the item price table.
package vend_pkg;

  localparam int unsigned CREDIT_W_DEFAULT = 8;
  localparam int unsigned COIN_W           = 4;
  localparam int unsigned PRICE_W          = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  // Indexed by the item select code; entry 0 is item0.
  localparam logic [3:0][PRICE_W-1:0] PRICE_TABLE = {4'd12, 4'd7, 4'd5, 4'd3};

  function automatic logic [COIN_W-1:0] coin_value(input logic [1:0] cn);
    case (cn)
      2'b01:   coin_value = COIN_W'(1);
      2'b10:   coin_value = COIN_W'(5);
      2'b11:   coin_value = COIN_W'(10);
      default: coin_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter; done is high once the count has reached zero.
// Load takes priority over counting.
module vend_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      done  <= 1'b1;
    end else if (load) begin
      count <= load_val;
      done  <= (load_val == '0);
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
      done  <= (count == W'(1));
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending session controller: coin credit, price check, timed dispense
// and unit-by-unit change return through a request/acknowledge handshake.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W    = CREDIT_W_DEFAULT,
  parameter int unsigned CREDIT_MAX  = 200,
  parameter int unsigned DISP_CYCLES = 8,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ST,
  input  logic [1:0]          CN,
  input  logic [1:0]          FS,
  input  logic                SEL_V,
  input  logic                CANCEL,
  input  logic                CHG_ACK,
  output logic                FD,
  output logic [1:0]          ITEM,
  output logic                CHG_REQ,
  output logic [CREDIT_W-1:0] CREDIT,
  output logic                BUSY,
  output logic                ERR_LOW,
  output logic                REJ
);

  localparam int unsigned SUM_W  = CREDIT_W + 1;
  localparam int unsigned DISP_W = $clog2(DISP_CYCLES + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic [1:0]          item_d;
  logic                err_d, rej_d;
  logic                disp_load, disp_en, disp_done;
  logic                tmo_load, tmo_en, tmo_done;
  logic [SUM_W-1:0]    sum, eff, price;
  logic                coin_ok;

  vend_timer #(.W(DISP_W)) u_disp_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (disp_load),
    .en       (disp_en),
    .load_val (DISP_W'(DISP_CYCLES - 1)),
    .done     (disp_done)
  );

  vend_timer #(.W(TMO_W)) u_tmo_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmo_load),
    .en       (tmo_en),
    .load_val (TMO_W'(TIMEOUT)),
    .done     (tmo_done)
  );

  // Effective credit if this cycle's coin is accepted; sum is one bit wider so it cannot wrap.
  always_comb begin
    sum     = SUM_W'(CREDIT) + SUM_W'(coin_value(CN));
    coin_ok = (CN != 2'b00) && (sum <= SUM_W'(CREDIT_MAX));
    eff     = coin_ok ? sum : SUM_W'(CREDIT);
    price   = SUM_W'(PRICE_TABLE[FS]);
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    credit_d  = CREDIT;
    item_d    = ITEM;
    err_d     = 1'b0;
    rej_d     = 1'b0;
    disp_load = 1'b0;
    disp_en   = 1'b0;
    tmo_load  = 1'b0;
    tmo_en    = 1'b0;
    case (state_q)
      IDLE: begin
        rej_d = (CN != 2'b00);
        if (ST) begin
          state_d  = COLLECT;
          tmo_load = 1'b1;
        end
      end
      COLLECT: begin
        rej_d    = (CN != 2'b00) && !coin_ok;
        credit_d = CREDIT_W'(eff);
        if (CANCEL) begin
          state_d = (eff != '0) ? CHANGE : IDLE;
        end else if (SEL_V) begin
          if (eff >= price) begin
            credit_d  = CREDIT_W'(eff - price);
            item_d    = FS;
            state_d   = DISPENSE;
            disp_load = 1'b1;
          end else begin
            err_d    = 1'b1;
            tmo_load = 1'b1;
          end
        end else if (coin_ok) begin
          tmo_load = 1'b1;
        end else if (tmo_done) begin
          state_d = (CREDIT != '0) ? CHANGE : IDLE;
        end else begin
          tmo_en = 1'b1;
        end
      end
      DISPENSE: begin
        rej_d = (CN != 2'b00);
        if (disp_done) state_d = (CREDIT != '0) ? CHANGE : IDLE;
        else           disp_en = 1'b1;
      end
      CHANGE: begin
        rej_d = (CN != 2'b00);
        if (CREDIT == '0) begin
          state_d = IDLE;
        end else if (CHG_REQ && CHG_ACK) begin
          credit_d = CREDIT - CREDIT_W'(1);
          if (CREDIT == CREDIT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs follow the next state so every response lands one edge after its cause.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CREDIT  <= '0;
      ITEM    <= '0;
      FD      <= 1'b0;
      CHG_REQ <= 1'b0;
      BUSY    <= 1'b0;
      ERR_LOW <= 1'b0;
      REJ     <= 1'b0;
    end else begin
      CREDIT  <= credit_d;
      ITEM    <= item_d;
      FD      <= (state_d == DISPENSE);
      CHG_REQ <= (state_d == CHANGE) && (credit_d != '0);
      BUSY    <= (state_d != IDLE);
      ERR_LOW <= err_d;
      REJ     <= rej_d;
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: a session-level reference model queues the
// expected outputs per cycle, and a negedge monitor pops and compares them.
module tb_vend_sequencer;

  typedef struct packed {
    logic       fd;
    logic [1:0] item;
    logic       chg_req;
    logic [7:0] credit;
    logic       busy;
    logic       err_low;
    logic       rej;
  } snap_t;

  localparam int P_IDLE = 0, P_COLLECT = 1, P_VEND = 2, P_REFUND = 3;

  logic       CLK, RST, ST, SEL_V, CANCEL, CHG_ACK;
  logic [1:0] CN, FS;
  logic       FD, CHG_REQ, BUSY, ERR_LOW, REJ;
  logic [1:0] ITEM;
  logic [7:0] CREDIT;

  snap_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc_no = 0;

  int m_phase = P_IDLE, m_credit = 0, m_item = 0, m_left = 0, m_quiet = 0;
  bit m_chg = 1'b0;

  vend_sequencer dut (
    .CLK     (CLK),
    .RST     (RST),
    .ST      (ST),
    .CN      (CN),
    .FS      (FS),
    .SEL_V   (SEL_V),
    .CANCEL  (CANCEL),
    .CHG_ACK (CHG_ACK),
    .FD      (FD),
    .ITEM    (ITEM),
    .CHG_REQ (CHG_REQ),
    .CREDIT  (CREDIT),
    .BUSY    (BUSY),
    .ERR_LOW (ERR_LOW),
    .REJ     (REJ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int coin_units(input int cn);
    case (cn)
      1:       return 1;
      2:       return 5;
      3:       return 10;
      default: return 0;
    endcase
  endfunction

  function automatic int price_of(input int fs);
    case (fs)
      0:       return 3;
      1:       return 5;
      2:       return 7;
      default: return 12;
    endcase
  endfunction

  function automatic int after_session(input int c);
    return (c > 0) ? P_REFUND : P_IDLE;
  endfunction

  // Session-level model of one clock edge; pushes the outputs expected after it.
  task automatic model(input bit rst, input bit st, input int cn, input int fs,
                       input bit sel, input bit cancel, input bit ack);
    int    v, eff;
    bit    ok, err, rej;
    snap_t s;
    err = 1'b0;
    rej = 1'b0;
    if (rst) begin
      m_phase = P_IDLE; m_credit = 0; m_item = 0; m_left = 0; m_quiet = 0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          rej = (cn != 0);
          if (st) begin m_phase = P_COLLECT; m_quiet = 0; end
        end
        P_COLLECT: begin
          v   = coin_units(cn);
          ok  = (v > 0) && (m_credit + v <= 200);
          rej = (v > 0) && !ok;
          eff = m_credit + (ok ? v : 0);
          if (cancel) begin
            m_credit = eff;
            m_phase  = after_session(eff);
          end else if (sel) begin
            if (eff >= price_of(fs)) begin
              m_credit = eff - price_of(fs);
              m_item   = fs;
              m_phase  = P_VEND;
              m_left   = 8;
            end else begin
              m_credit = eff;
              err      = 1'b1;
              m_quiet  = 0;
            end
          end else if (ok) begin
            m_credit = eff;
            m_quiet  = 0;
          end else if (m_quiet == 255) begin
            m_phase = after_session(m_credit);
          end else begin
            m_quiet++;
          end
        end
        P_VEND: begin
          rej = (cn != 0);
          m_left--;
          if (m_left == 0) m_phase = after_session(m_credit);
        end
        default: begin
          rej = (cn != 0);
          if (m_chg && ack) begin
            m_credit--;
            if (m_credit == 0) m_phase = P_IDLE;
          end
        end
      endcase
    end
    m_chg     = (m_phase == P_REFUND) && (m_credit > 0);
    s.fd      = (m_phase == P_VEND);
    s.item    = 2'(m_item);
    s.chg_req = m_chg;
    s.credit  = 8'(m_credit);
    s.busy    = (m_phase != P_IDLE);
    s.err_low = err;
    s.rej     = rej;
    exp_q.push_back(s);
  endtask

  task automatic cyc(input bit rst, input bit st, input int cn, input int fs,
                     input bit sel, input bit cancel, input bit ack);
    RST = rst; ST = st; CN = 2'(cn); FS = 2'(fs);
    SEL_V = sel; CANCEL = cancel; CHG_ACK = ack;
    model(rst, st, cn, fs, sel, cancel, ack);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, ack);
  endtask

  // Monitor: every edge presents a registered output set; compare with the oldest expectation.
  always @(negedge CLK) begin
    snap_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {FD, ITEM, CHG_REQ, CREDIT, BUSY, ERR_LOW, REJ};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle %0d outputs: got fd=%0b item=%0d req=%0b credit=%0d busy=%0b err=%0b rej=%0b, want fd=%0b item=%0d req=%0b credit=%0d busy=%0b err=%0b rej=%0b",
                 cyc_no, a.fd, a.item, a.chg_req, a.credit, a.busy, a.err_low, a.rej,
                 e.fd, e.item, e.chg_req, e.credit, e.busy, e.err_low, e.rej);
      end
      cyc_no++;
    end
  end

  initial begin
    int cn, fs;
    bit rst, st, sel, cancel, ack;

    idle(0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Credit 15, buy item3, coin refused mid-dispense, return 3 units.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 3, 0, 0, 0, 0);
    cyc(0, 0, 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 3, 1, 0, 0);
    idle(3, 0);
    cyc(0, 0, 2, 0, 0, 0, 0);
    idle(6, 0);
    idle(5, 1);

    // Insufficient credit, then coin and select in the same cycle.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 2, 1, 1, 0, 0);
    idle(9, 0);
    idle(3, 1);

    // Credit ceiling: 195, refused 10, accepted 5 -> 200, then cancel and refund.
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 19; i++) cyc(0, 0, 3, 0, 0, 0, 0);
    cyc(0, 0, 2, 0, 0, 0, 0);
    cyc(0, 0, 3, 0, 0, 0, 0);
    cyc(0, 0, 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(205, 1);

    // Timeout with 5 units, slow change return, then cancel beating select.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 2, 0, 0, 0, 0);
    idle(262, 0);
    idle(8, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 2, 1, 1, 0);
    idle(3, 1);

    // Coins in IDLE and acknowledge without request.
    cyc(0, 0, 3, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 1);
    idle(2, 1);

    // Reset during the 4th FD cycle.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 3, 0, 0, 0, 0);
    cyc(0, 0, 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle(3, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(3, 1);

    // Randomized sessions.
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 599) == 0);
      st     = ($urandom_range(0, 7) == 0);
      cn     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      fs     = int'($urandom_range(0, 3));
      sel    = ($urandom_range(0, 9) == 0);
      cancel = ($urandom_range(0, 39) == 0);
      ack    = $urandom_range(0, 1) == 1;
      cyc(rst, st, cn, fs, sel, cancel, ack);
    end

    @(negedge CLK);
    @(negedge CLK);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
